// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice, one nibble per cycle, LSB first.
// Optional macro NSA_SUB_EN adds a 'sub' input that turns the operation into a - b.
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Returns {carry_out, sum[3:0]} with all four carries computed in parallel.
    function automatic logic [4:0] fast_fadd4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] nib_mask;
    logic [WIDTH-1:0] nib_ins;
    logic [4:0]       add;

`ifdef NSA_SUB_EN
    // Subtraction is a + ~b + 1, so the external carry-in is overridden.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    always_comb begin
        a_sh     = a_q >> {cnt, 2'b00};
        b_sh     = b_q >> {cnt, 2'b00};
        add      = fast_fadd4(a_sh[3:0], b_sh[3:0], carry);
        nib_mask = WIDTH'(4'hF) << {cnt, 2'b00};
        nib_ins  = WIDTH'(add[3:0]) << {cnt, 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        carry <= c_in;
                        cnt   <= '0;
                        sum_q <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q <= (sum_q & ~nib_mask) | nib_ins;
                    carry <= add[4];
                    if (cnt == LAST) begin
                        cout_q <= add[4];
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add[3] != a_q[WIDTH-1]);
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases plus randomized operations against a
// transaction-level reference (plain integer arithmetic and an accept-to-result latency of NIB edges).
module tb_nibble_serial_adder;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             cin = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
`ifdef NSA_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             in_ready;
    logic             out_valid;
    logic             cout;
    logic             overflow;
    logic [WIDTH-1:0] sum;

    int tests = 0;
    int fails = 0;
    int hs = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef NSA_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .overflow(overflow)
    );

    task automatic chk(input string name, input logic [WIDTH+1:0] got, input logic [WIDTH+1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: {overflow, cout, sum} from integer arithmetic on the operand values.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic c, input logic s);
        longint           sx;
        longint           sy;
        longint           sr;
        longint           ur;
        logic [WIDTH-1:0] r;
        logic             co;
        logic             ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            sr = sx - sy;
            r  = x - y;
            co = (x >= y);
        end else begin
            ur = longint'(x) + longint'(y) + longint'(c);
            r  = ur[WIDTH-1:0];
            co = ur[WIDTH];
            sr = sx + sy + longint'(c);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, r};
    endfunction

    // Transaction model: one op outstanding; result visible NIB edges after the accept edge.
    logic             m_busy = 1'b0;
    int               cyc = 0;
    int               acc_cyc = 0;
    logic [WIDTH+1:0] m_res = '0;
    logic [WIDTH+1:0] m_last = '0;
    logic             m_sub;

`ifdef NSA_SUB_EN
    assign m_sub = sub;
`else
    assign m_sub = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_last  <= '0;
            cyc     <= 0;
            acc_cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy && in_valid) begin
                m_busy  <= 1'b1;
                acc_cyc <= cyc + 1;
                m_res   <= ref_op(a, b, cin, m_sub);
            end else if (m_busy && (cyc - acc_cyc >= NIB) && out_ready) begin
                m_busy <= 1'b0;
                m_last <= m_res;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs <= hs + 1;
    end

    always @(negedge clk) begin
        logic exp_v;
        exp_v = m_busy && (cyc - acc_cyc >= NIB);
        chk("out_valid", {{(WIDTH+1){1'b0}}, out_valid}, {{(WIDTH+1){1'b0}}, exp_v});
        chk("in_ready", {{(WIDTH+1){1'b0}}, in_ready}, {{(WIDTH+1){1'b0}}, !m_busy});
        if (exp_v) begin
            chk("result", {overflow, cout, sum}, m_res);
        end else if (!m_busy) begin
            chk("idle_hold", {overflow, cout, sum}, m_last);
        end
    end

    task automatic wait_sig(input string name, input bit want_ready);
        int n;
        n = 0;
        while ((want_ready ? in_ready : out_valid) !== 1'b1 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if ((want_ready ? in_ready : out_valid) !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting, got 0, expected 1", name);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b, input logic tc,
                          input logic ts, input int hold);
        wait_sig("wait_in_ready", 1'b1);
        a   = ta;
        b   = tb_b;
        cin = tc;
`ifdef NSA_SUB_EN
        sub = ts;
`else
        if (ts) $display("note: subtract requested without NSA_SUB_EN");
`endif
        in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        wait_sig("wait_out_valid", 1'b0);
        repeat (hold) begin
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("reset_state", {out_valid, in_ready, sum}, {1'b0, 1'b1, 32'h0});
        @(negedge clk); #1;
        rst_n = 1'b1;

        chk("model_pin_add", ref_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b10, 32'h8000_0000});
        chk("model_pin_sub", ref_op(32'h5, 32'h7, 1'b0, 1'b1), {2'b00, 32'hFFFF_FFFE});

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 0);
        chk("t1_small", {overflow, cout, sum}, {2'b00, 32'h0000_0008});

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        chk("t2_ripple", {overflow, cout, sum}, {2'b01, 32'h0000_0000});

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5);
        chk("t3_overflow", {overflow, cout, sum}, {2'b10, 32'h8000_0000});

        // Operands and in_valid wiggle while busy; only the first op may complete.
        wait_sig("t4_ready", 1'b1);
        hs0 = hs;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk); #1;
        repeat (3) begin
            a = $urandom; b = $urandom; cin = 1'b1;
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        wait_sig("t4_out_valid", 1'b0);
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
        end
        chk("t4_result", {2'b00, sum}, {2'b00, 32'h2345_6789});
        chk("t4_handshakes", (WIDTH+2)'(hs - hs0), (WIDTH+2)'(1));

        // Reset in the middle of BUSY discards the partial result.
        wait_sig("t5_ready", 1'b1);
        a = 32'hAAAA_AAAA; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t5_reset_mid", {out_valid, in_ready, sum}, {1'b0, 1'b1, 32'h0});
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("t5_after_release", {out_valid, in_ready, sum}, {1'b0, 1'b1, 32'h0});
        run_op(32'h10, 32'h20, 1'b0, 1'b0, 0);
        chk("t5_fresh", {overflow, cout, sum}, {2'b00, 32'h0000_0030});

`ifdef NSA_SUB_EN
        run_op(32'h5, 32'h7, 1'b1, 1'b1, 0);
        chk("t6_sub_neg", {overflow, cout, sum}, {2'b00, 32'hFFFF_FFFE});
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 0);
        chk("t6_sub_ovf", {overflow, cout, sum}, {2'b11, 32'h7FFF_FFFF});
`endif

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 1) ra = 32'hFFFF_FFFF;
            if (i % 8 == 2) rb = 32'h8000_0000;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #1;
            end
`ifdef NSA_SUB_EN
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
`else
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
`endif
        end

        repeat (3) begin
            @(negedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-lookahead adder (`fast_fadd4`).
- Processes one nibble per cycle, LSB nibble first, and chains the carry through a register.
- Serves area-constrained paths in the npc core where a full-width adder is too expensive.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4 and ≥4.
- NIB, WIDTH/4 (localparam), number of nibble steps.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b and cin are valid.
- in_ready  out  1  block accepts operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  out  1  unsigned carry-out.
- overflow  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, nibble counter=0, carry reg=0.
  - Operand regs a_q/b_q=0, sum=0, cout=0, overflow=0, out_valid=0.
  - in_ready=1 after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q←a, b_q←b, carry←cin, cnt←0, clear sum←0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle the adder sees a_q[4cnt+3:4cnt], b_q[4cnt+3:4cnt] and the carry reg.
  - sum[4cnt+3:4cnt]←adder sum; carry←adder cout; cnt←cnt+1.
  - When cnt==NIB-1: cout←adder cout; overflow←(a_q[W-1]==b_q[W-1])&&(new sum MSB!=a_q[W-1]); go to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On out_ready: out_valid←0, go to IDLE.
  - sum, cout and overflow keep their values until the next accept.
- Latency: accept edge + NIB BUSY cycles; out_valid rises on the NIB-th edge after the accept edge.
- Throughput: one operation per NIB+2 cycles when out_ready is tied high.
- Inputs a, b and cin are ignored outside the accept cycle; changing them in BUSY or DONE has no effect.
- in_valid while BUSY or DONE is not accepted; no queuing.
- out_ready outside DONE is ignored.
- Back-to-back: DONE→IDLE takes one cycle, so in_ready rises the cycle after the result handshake. There is no same-cycle accept in DONE.
- WIDTH=4: BUSY lasts exactly one cycle.
- cnt width is clog2(NIB) with a minimum of 1; cnt never exceeds NIB-1.
- Reset asserted mid-BUSY or mid-DONE: immediate return to IDLE with all outputs at reset values; the partial result is discarded.

Optional Feature:
- Macro NSA_SUB_EN adds input port `sub` (1 bit), latched at accept.
- When sub=1: b_q←~b and carry←1, so cin is ignored and the result is a−b.
- Overflow uses the inverted b_q MSB.
- cout=1 means no borrow.
- Without the macro there is no `sub` port and the block only adds.

Test Plan:
1. WIDTH=32, a=0x0000_0005, b=0x0000_0003, cin=0 → after 8 BUSY cycles out_valid=1, sum=0x0000_0008, cout=0, overflow=0.
2. a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0x0000_0000, cout=1, overflow=0; this checks the full carry ripple across all 8 nibbles.
3. a=0x7FFF_FFFF, b=0x0000_0001 → sum=0x8000_0000, cout=0, overflow=1. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
4. Accept a=0x1234_5678, b=0x1111_1111. Change a/b and pulse in_valid during BUSY → result is still 0x2345_6789, and only one result handshake occurs.
5. Assert rst_n=0 at BUSY cycle 4 → out_valid=0, sum=0, in_ready=1 after release. A fresh op 0x10+0x20 then yields 0x30.
6. With NSA_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFF_FFFE, cout=0, overflow=0. a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, overflow=1.
